// File: rtl/conv_window_feeder.sv
// ---------------------------------------------------------------------------
// conv_window_feeder
//
// Producer-side companion to the 3x3 convolution engine. Walks an
// IMG_W x IMG_H image in raster order, fetches each 3x3 window from image
// memory, presents it to the engine, pulses conv_start, waits for conv_save
// and writes the returned 8-bit result into the (IMG_W-2) x (IMG_H-2)
// feature map (valid convolution, stride 1).
//
// Optional feature macro: WINDOW_REUSE_EN
//   When defined, windows with col>0 reuse the two left columns of the
//   previous window (shift left) and only fetch the new right column
//   (3 reads, 4-cycle FETCH). Results are identical either way.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a full-image pass (sampled in IDLE only)
//   img_rd_en, img_addr      image memory read request (data 1 cycle later)
//   img_rdata                image read data
//   win_data                 3x3 window, slot k=r*3+c at [k*DW +: DW]
//   conv_start               one-cycle start pulse to the engine
//   conv_save, conv_result   engine result strobe and 8-bit result
//   fm_we, fm_addr, fm_wdata feature-map write port
//   busy, done               pass in progress / end-of-pass pulse
//   dbg_state                current FSM state (debug visibility)
//
// Handshake: conv_start is a single-cycle request; the engine answers with
// a single-cycle conv_save carrying conv_result. conv_save is only honoured
// in WAIT, and win_data is held stable from START until WAIT ends.
// All outputs are driven directly from registers.
// ---------------------------------------------------------------------------
module conv_window_feeder #(
  parameter int dataWidthConv = 16,
  parameter int IMG_W         = 28,
  parameter int IMG_H         = 28,
  parameter int ADDR_W        = 10,
  parameter int FM_ADDR_W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       img_rd_en,
  output logic [ADDR_W-1:0]          img_addr,
  input  logic [dataWidthConv-1:0]   img_rdata,
  output logic [9*dataWidthConv-1:0] win_data,
  output logic                       conv_start,
  input  logic                       conv_save,
  input  logic [7:0]                 conv_result,
  output logic                       fm_we,
  output logic [FM_ADDR_W-1:0]       fm_addr,
  output logic [7:0]                 fm_wdata,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 dbg_state
);

  localparam int DW = dataWidthConv;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_ADV   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                reuse_q, reuse_d;
  logic [7:0]          result_q, result_d;
  logic [9*DW-1:0]     win_q, win_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cstart_q, cstart_d;
  logic                we_q, we_d;
  logic [FM_ADDR_W-1:0] fm_addr_q, fm_addr_d;
  logic [7:0]          fm_wdata_q, fm_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, counters, window slots and captured result.
  always_comb begin
    int cap_k;
    int slot;
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    reuse_d  = reuse_q;
    result_d = result_q;
    win_d    = win_q;
    cap_k    = int'(cnt_q) - 1;
    slot     = reuse_q ? (cap_k * 3 + 2) : cap_k;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          reuse_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q + 4'd1;
        // Reuse mode: first cycle slides the two right columns to the left.
        if (reuse_q && cnt_q == 4'd0) begin
          for (int r = 0; r < 3; r++) begin
            win_d[(r*3)*DW   +: DW] = win_q[(r*3+1)*DW +: DW];
            win_d[(r*3+1)*DW +: DW] = win_q[(r*3+2)*DW +: DW];
          end
        end
        // Read data lags its issue by one cycle, so cycle n fills issue n-1.
        if (cnt_q != 4'd0) begin
          for (int k = 0; k < 9; k++) begin
            if (k == slot) win_d[k*DW +: DW] = img_rdata;
          end
        end
        if (cnt_q == (reuse_q ? 4'd3 : 4'd9)) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (conv_save) begin
          result_d = conv_result;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: state_d = S_ADV;
      S_ADV: begin
        cnt_d = '0;
        if (col_q < CW'(IMG_W - 3)) begin
          col_d   = col_q + CW'(1);
          reuse_d = REUSE;
          state_d = S_FETCH;
        end else begin
          col_d   = '0;
          reuse_d = 1'b0;
          if (row_q < RW'(IMG_H - 3)) begin
            row_d   = row_q + RW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state so that each
  // output is valid during the cycle its state is active.
  always_comb begin
    int iss_r;
    int iss_c;
    logic issuing;
    iss_r   = 0;
    iss_c   = 0;
    issuing = (state_d == S_FETCH) && (cnt_d < (reuse_d ? 4'd3 : 4'd9));
    if (reuse_d) begin
      iss_r = int'(cnt_d);
      iss_c = 2;
    end else begin
      iss_r = int'(cnt_d) / 3;
      iss_c = int'(cnt_d) % 3;
    end
    rd_en_d    = issuing;
    addr_d     = issuing ? ADDR_W'((int'(row_d) + iss_r) * IMG_W + int'(col_d) + iss_c)
                         : '0;
    cstart_d   = (state_d == S_START);
    we_d       = (state_d == S_WRITE);
    fm_addr_d  = (state_d == S_WRITE) ? FM_ADDR_W'(int'(row_d) * (IMG_W - 2) + int'(col_d))
                                      : '0;
    fm_wdata_d = (state_d == S_WRITE) ? result_d : 8'd0;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      reuse_q    <= 1'b0;
      result_q   <= '0;
      win_q      <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      cstart_q   <= 1'b0;
      we_q       <= 1'b0;
      fm_addr_q  <= '0;
      fm_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      reuse_q    <= reuse_d;
      result_q   <= result_d;
      win_q      <= win_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      cstart_q   <= cstart_d;
      we_q       <= we_d;
      fm_addr_q  <= fm_addr_d;
      fm_wdata_q <= fm_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign img_rd_en  = rd_en_q;
  assign img_addr   = addr_q;
  assign win_data   = win_q;
  assign conv_start = cstart_q;
  assign fm_we      = we_q;
  assign fm_addr    = fm_addr_q;
  assign fm_wdata   = fm_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;
  localparam int DW = 16, W = 5, H = 5, AW = 10, FAW = 10;
  localparam int OW = W - 2, OH = H - 2, NPIX = W * H, NWIN = OW * OH;
`ifdef WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic img_rd_en;
  logic [AW-1:0] img_addr;
  logic [DW-1:0] img_rdata = '0;
  logic [9*DW-1:0] win_data;
  logic conv_start;
  logic conv_save;
  logic [7:0] conv_result;
  logic fm_we;
  logic [FAW-1:0] fm_addr;
  logic [7:0] fm_wdata;
  logic busy, done;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  conv_window_feeder #(.dataWidthConv(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FM_ADDR_W(FAW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
    .win_data(win_data), .conv_start(conv_start), .conv_save(conv_save),
    .conv_result(conv_result), .fm_we(fm_we), .fm_addr(fm_addr), .fm_wdata(fm_wdata),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- image memory and engine models ----------------
  logic [DW-1:0] img_mem [0:NPIX-1];

  always @(posedge clk) img_rdata <= (img_addr < AW'(NPIX)) ? img_mem[img_addr] : '0;

  int   eng_delay = 3;
  bit   eng_mode  = 1'b0;   // 0: centre slot, 1: position-weighted sum
  int   eng_cnt   = 0;
  logic eng_save  = 1'b0;
  logic spur_save = 1'b0;
  logic [7:0] eng_res = '0;

  function automatic logic [7:0] engine_fn(input logic [9*DW-1:0] w, input bit mode);
    logic [31:0] s;
    s = '0;
    if (!mode) return w[4*DW +: 8];
    for (int k = 0; k < 9; k++) s = s + 32'(k + 1) * 32'(w[k*DW +: DW]);
    return s[7:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt <= 0; eng_save <= 1'b0; eng_res <= '0;
    end else begin
      eng_save <= 1'b0;
      if (conv_start) begin
        eng_res <= engine_fn(win_data, eng_mode);
        if (eng_delay <= 1) eng_save <= 1'b1;
        else eng_cnt <= eng_delay - 1;
      end else if (eng_cnt != 0) begin
        if (eng_cnt == 1) eng_save <= 1'b1;
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign conv_save   = eng_save | spur_save;
  assign conv_result = eng_res;

  // ---------------- monitor ----------------
  logic [AW-1:0]   rd_log[$];
  logic [FAW-1:0]  wa_log[$];
  logic [7:0]      wd_log[$];
  logic [9*DW-1:0] win_log[$];
  int start_pulses, done_pulses, win_changes, busy_seen, gap_min, gap_max, cyc, last_start;
  logic [9*DW-1:0] win_ref;
  bit waiting;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (img_rd_en === 1'b1) rd_log.push_back(img_addr);
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) done_pulses++;
      if (fm_we === 1'b1) begin
        wa_log.push_back(fm_addr);
        wd_log.push_back(fm_wdata);
        waiting = 1'b0;
        if (cyc - last_start < gap_min) gap_min = cyc - last_start;
        if (cyc - last_start > gap_max) gap_max = cyc - last_start;
      end
      if (conv_start === 1'b1) begin
        start_pulses++;
        win_ref = win_data;
        win_log.push_back(win_data);
        waiting = 1'b1;
        last_start = cyc;
      end else if (waiting && win_data !== win_ref) begin
        win_changes++;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete(); win_log.delete();
    start_pulses = 0; done_pulses = 0; win_changes = 0; busy_seen = 0;
    gap_min = 1000000; gap_max = 0; waiting = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [AW-1:0]   exp_rd_q[$];
  logic [FAW-1:0]  exp_wa_q[$];
  logic [7:0]      exp_q[$];
  logic [9*DW-1:0] exp_win_q[$];

  // Raster walk over output positions; each window is assembled straight
  // from the image array, and reads follow the fetch policy.
  task automatic build_model();
    logic [9*DW-1:0] w;
    exp_rd_q.delete(); exp_wa_q.delete(); exp_q.delete(); exp_win_q.delete();
    for (int row = 0; row < OH; row++) begin
      for (int col = 0; col < OW; col++) begin
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = img_mem[(row + k / 3) * W + col + k % 3];
        exp_win_q.push_back(w);
        exp_wa_q.push_back(FAW'(row * OW + col));
        exp_q.push_back(engine_fn(w, eng_mode));
        if (REUSE && col > 0) begin
          for (int r = 0; r < 3; r++) exp_rd_q.push_back(AW'((row + r) * W + col + 2));
        end else begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) exp_rd_q.push_back(AW'((row + r) * W + col + c));
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done_pulses < 1 && n < budget) begin
      @(negedge clk); n++;
    end
    ok = (done_pulses >= 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) img_mem[i] = DW'($urandom_range(0, 65535));
  endtask

  task automatic fill_address();
    for (int i = 0; i < NPIX; i++) img_mem[i] = DW'(i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rd_hi, we_hi;
    #3 rst = 1'b1;   // mid-cycle, asynchronous
    #1;
    checks++; if (img_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", img_rd_en); end
    checks++; if (img_addr !== '0) begin errors++; $display("FAIL reset_img_addr got %0d want 0", img_addr); end
    checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data got %h want 0", win_data); end
    checks++; if (conv_start !== 1'b0) begin errors++; $display("FAIL reset_conv_start got %b want 0", conv_start); end
    checks++; if ({fm_we, fm_addr, fm_wdata} !== '0) begin errors++; $display("FAIL reset_fm got %b/%0d/%0d want 0", fm_we, fm_addr, fm_wdata); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_hi = 0; we_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (img_rd_en !== 1'b0) rd_hi++;
      if (fm_we !== 1'b0) we_hi++;
    end
    checks++; if (rd_hi != 0 || we_hi != 0) begin errors++; $display("FAIL idle_activity got rd=%0d we=%0d want 0/0", rd_hi, we_hi); end
  endtask

  task automatic test_full_pass();
    bit ok;
    logic [7:0] spec_data [0:8];
    logic [AW-1:0] spec_addr [0:8];
    spec_data = '{8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18};
    spec_addr = '{10'd0, 10'd1, 10'd2, 10'd5, 10'd6, 10'd7, 10'd10, 10'd11, 10'd12};
    fill_address(); eng_mode = 1'b0; eng_delay = 3;
    build_model(); clear_logs();
    pulse_start();
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout got no done want done"); end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL full_done_count got %0d want 1", done_pulses); end
    checks++; if (wa_log.size() != NWIN) begin errors++; $display("FAIL full_write_count got %0d want %0d", wa_log.size(), NWIN); end
    for (int i = 0; i < NWIN && i < wa_log.size(); i++) begin
      checks++; if (wa_log[i] !== FAW'(i) || wd_log[i] !== spec_data[i]) begin
        errors++; $display("FAIL full_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa_log[i], wd_log[i], i, spec_data[i]);
      end
    end
    checks++; if (rd_log.size() != (REUSE ? 45 : 81)) begin errors++; $display("FAIL full_read_count got %0d want %0d", rd_log.size(), REUSE ? 45 : 81); end
    for (int i = 0; i < 9 && i < rd_log.size(); i++) begin
      checks++; if (rd_log[i] !== spec_addr[i]) begin errors++; $display("FAIL first_window_addr[%0d] got %0d want %0d", i, rd_log[i], spec_addr[i]); end
    end
    for (int i = 0; i < exp_rd_q.size() && i < rd_log.size(); i++) begin
      checks++; if (rd_log[i] !== exp_rd_q[i]) begin errors++; $display("FAIL read_seq[%0d] got %0d want %0d", i, rd_log[i], exp_rd_q[i]); end
    end
    checks++; if (gap_min != 4 || gap_max != 4) begin errors++; $display("FAIL full_latency got %0d..%0d want 4", gap_min, gap_max); end
    checks++; if (busy_seen == 0 || busy !== 1'b0) begin errors++; $display("FAIL full_busy got seen=%0d end=%b want >0/0", busy_seen, busy); end
  endtask

  task automatic test_random_windows();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      fill_random(); eng_mode = 1'b1; eng_delay = $urandom_range(1, 8);
      build_model(); clear_logs();
      pulse_start();
      wait_done(4000, ok);
      checks++; if (!ok || wa_log.size() != NWIN) begin errors++; $display("FAIL rand_writes got ok=%0d n=%0d want 1/%0d", ok, wa_log.size(), NWIN); end
      for (int i = 0; i < NWIN && i < wa_log.size(); i++) begin
        checks++; if (wa_log[i] !== exp_wa_q[i] || wd_log[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa_log[i], wd_log[i], exp_wa_q[i], exp_q[i]);
        end
      end
      for (int i = 0; i < NWIN && i < win_log.size(); i++) begin
        checks++; if (win_log[i] !== exp_win_q[i]) begin errors++; $display("FAIL rand_window[%0d] got %h want %h", i, win_log[i], exp_win_q[i]); end
      end
      checks++; if (rd_log.size() != exp_rd_q.size()) begin errors++; $display("FAIL rand_read_count got %0d want %0d", rd_log.size(), exp_rd_q.size()); end
    end
  endtask

  task automatic test_handshake();
    bit ok;
    fill_random(); eng_mode = 1'b0; eng_delay = 50;
    build_model(); clear_logs();
    pulse_start();
    wait_done(10000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_timeout got no done want done"); end
    checks++; if (start_pulses != NWIN) begin errors++; $display("FAIL hs_start_pulses got %0d want %0d", start_pulses, NWIN); end
    checks++; if (win_changes != 0) begin errors++; $display("FAIL hs_window_stable got %0d changes want 0", win_changes); end
    checks++; if (gap_min != 51 || gap_max != 51) begin errors++; $display("FAIL hs_latency got %0d..%0d want 51", gap_min, gap_max); end
    checks++; if (wa_log.size() != NWIN) begin errors++; $display("FAIL hs_write_count got %0d want %0d", wa_log.size(), NWIN); end
    for (int i = 0; i < NWIN && i < wd_log.size(); i++) begin
      checks++; if (wd_log[i] !== exp_q[i]) begin errors++; $display("FAIL hs_write[%0d] got %0d want %0d", i, wd_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_spurious();
    bit spur_done, st_done;
    int n, rd_after;
    fill_random(); eng_mode = 1'b0; eng_delay = 3;
    build_model(); clear_logs();
    pulse_start();
    spur_done = 1'b0; st_done = 1'b0; n = 0;
    while (done_pulses < 1 && n < 4000) begin
      @(negedge clk); n++;
      spur_save = 1'b0; start = 1'b0;
      if (!spur_done && wa_log.size() == 1 && img_rd_en === 1'b1) begin spur_save = 1'b1; spur_done = 1'b1; end
      else if (!st_done && wa_log.size() == 3) begin start = 1'b1; st_done = 1'b1; end
    end
    spur_save = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rd_after = rd_log.size();
    repeat (20) @(negedge clk);
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL spur_done got %0d want 1", done_pulses); end
    checks++; if (wa_log.size() != NWIN) begin errors++; $display("FAIL spur_write_count got %0d want %0d", wa_log.size(), NWIN); end
    for (int i = 0; i < NWIN && i < wa_log.size(); i++) begin
      checks++; if (wa_log[i] !== exp_wa_q[i] || wd_log[i] !== exp_q[i]) begin
        errors++; $display("FAIL spur_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa_log[i], wd_log[i], exp_wa_q[i], exp_q[i]);
      end
    end
    checks++; if (rd_log.size() != rd_after || busy !== 1'b0) begin errors++; $display("FAIL spur_restart got reads=%0d busy=%b want %0d/0", rd_log.size(), busy, rd_after); end
  endtask

  task automatic test_reset_midpass();
    bit ok;
    int n;
    fill_address(); eng_mode = 1'b0; eng_delay = 3;
    build_model(); clear_logs();
    pulse_start();
    n = 0;
    while (wa_log.size() < 4 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (wa_log.size() != 4) begin errors++; $display("FAIL mid_reach4 got %0d writes want 4", wa_log.size()); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++; if ({img_rd_en, conv_start, fm_we, busy, done} !== 5'b0 || win_data !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got %b win=%h want 0", {img_rd_en, conv_start, fm_we, busy, done}, win_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (wa_log.size() != 4 || busy !== 1'b0) begin errors++; $display("FAIL mid_abandon got writes=%0d busy=%b want 4/0", wa_log.size(), busy); end
    clear_logs();
    pulse_start();
    wait_done(3000, ok);
    checks++; if (!ok || wa_log.size() != NWIN) begin errors++; $display("FAIL mid_rerun got ok=%0d n=%0d want 1/%0d", ok, wa_log.size(), NWIN); end
    for (int i = 0; i < NWIN && i < wa_log.size(); i++) begin
      checks++; if (wa_log[i] !== FAW'(i) || wd_log[i] !== exp_q[i]) begin
        errors++; $display("FAIL mid_rerun_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa_log[i], wd_log[i], i, exp_q[i]);
      end
    end
    checks++; if (wd_log.size() == 0 || wd_log[0] !== 8'd6) begin errors++; $display("FAIL mid_first_data got %0d want 6", wd_log.size() ? wd_log[0] : 8'hxx); end
  endtask

  initial begin
    clear_logs();
    cyc = 0; last_start = 0;
    test_reset();
    test_full_pass();
    test_random_windows();
    test_handshake();
    test_spurious();
    test_reset_midpass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer-side companion to the 3x3 convolution engine.
- Walks a stored IMG_W x IMG_H image in raster order and fetches each 3x3 window from image memory.
- Presents the window to the engine, pulses the engine's start, and waits for the engine's save strobe.
- Writes the returned 8-bit quantized result into the feature-map memory. Output map is (IMG_W-2) x (IMG_H-2), valid convolution, stride 1.

Parameters:
- dataWidthConv, 16, pixel width, matching the engine's data inputs.
- IMG_W, 28, image width in pixels (>=3).
- IMG_H, 28, image height in pixels (>=3).
- ADDR_W, 10, image memory address width (2^ADDR_W >= IMG_W*IMG_H).
- FM_ADDR_W, 10, feature-map address width (2^FM_ADDR_W >= (IMG_W-2)*(IMG_H-2)).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a full-image pass; sampled only in IDLE.
- img_rd_en  out  1  image memory read enable.
- img_addr  out  ADDR_W  image read address; data returns 1 cycle later.
- img_rdata  in  dataWidthConv  image read data.
- win_data  out  9*dataWidthConv  window; slot k=r*3+c at [k*dataWidthConv +: dataWidthConv].
- conv_start  out  1  one-cycle start pulse to the engine.
- conv_save  in  1  engine result-valid strobe.
- conv_result  in  8  engine quantized output.
- fm_we  out  1  feature-map write enable.
- fm_addr  out  FM_ADDR_W  feature-map write address.
- fm_wdata  out  8  feature-map write data.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: async assert forces state IDLE. row, col, window slots, result register and all outputs go to 0. Reset mid-pass abandons the pass and issues no further writes.
- States: IDLE -> FETCH -> START -> WAIT -> WRITE -> ADV -> (FETCH | DONE) -> IDLE.
- IDLE: if start=1, clear row and col, then go to FETCH.
- FETCH: issues reads k=0..8 on consecutive cycles with img_rd_en=1 and img_addr=(row+r)*IMG_W+(col+c). Data for issue k is captured into slot k on the following cycle. FETCH lasts 10 cycles, then goes to START.
- START: conv_start=1 for exactly one cycle, then go to WAIT.
- win_data: held stable from START through the end of WAIT.
- WAIT: stays until conv_save=1 is sampled. On that cycle, captures conv_result and goes to WRITE. No timeout. conv_save is ignored in every other state.
- WRITE: for one cycle, fm_we=1, fm_addr=row*(IMG_W-2)+col, fm_wdata=captured result.
- ADV:
  - If col<IMG_W-3, increment col and go to FETCH.
  - Else col=0. If row<IMG_H-3, increment row and go to FETCH; else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start while busy: ignored. start and rst together: rst wins.
- Address arithmetic is unsigned; no wrap-around is possible within the parameter constraints.
- Every output is registered.

Optional Feature:
- WINDOW_REUSE_EN defined:
  - When col>0, in the first FETCH cycle slots shift left by one column (c0<-c1, c1<-c2 for each row).
  - Only column c=2 is read, as 3 issues in order r=0,1,2 into slots 2, 5 and 8. FETCH lasts 4 cycles.
  - At col=0, a full 9-read fetch is done.
- Not defined: every window is a full 9-read fetch. Results are identical either way; only cycle count and read count differ.

Test Plan:
- Reset/idle: assert rst mid-cycle -> all outputs 0 immediately; with no start for 20 cycles -> img_rd_en=0, fm_we=0.
- Full pass, IMG_W=IMG_H=5, pixel value equals its address, engine model returns conv_save 3 cycles after conv_start with result = centre slot (slot 4) -> 9 writes, fm_addr 0..8, data 6,7,8,11,12,13,16,17,18, then one done pulse.
- Read addressing, same setup: first window -> img_addr sequence 0,1,2,5,6,7,10,11,12. Read count over the pass: 81 without WINDOW_REUSE_EN, 45 with it. Second window with WINDOW_REUSE_EN -> addresses 3,8,13 only.
- Handshake: engine delays conv_save by 50 cycles -> conv_start pulses once, win_data unchanged for all 50 cycles, exactly one fm_we.
- Spurious stimulus: conv_save pulsed during FETCH and start pulsed mid-pass -> no extra write, no restart, write sequence unchanged.
- Reset mid-pass: assert rst after the 4th write, then restart -> the second pass writes addresses 0..8 again, first write data 6.
